// File: rtl/trapezoid_bank.sv
// trapezoid_bank: N_TERMS trapezoidal membership functions, one term evaluated at a time (restoring divider).
// Build option: define TRAPEZOID_BANK_FASTPATH_EN to let plateau/outside terms skip the 15-cycle DIV phase.
module trapezoid_bank #(
  parameter int DATA_W  = 8,
  parameter int N_TERMS = 4,
  parameter int IDX_W   = $clog2(N_TERMS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [IDX_W-1:0]         cfg_idx,
  input  logic signed [DATA_W-1:0] cfg_a,
  input  logic signed [DATA_W-1:0] cfg_b,
  input  logic signed [DATA_W-1:0] cfg_c,
  input  logic signed [DATA_W-1:0] cfg_d,
  output logic                     cfg_drop,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_idx,
  output logic [15:0]              out_mu,
  output logic                     out_last
);

  typedef enum logic [1:0] {IDLE, EVAL, DIV, OUT} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TERMS - 1);

  function automatic logic signed [DATA_W:0] sext(input logic signed [DATA_W-1:0] v);
    return {v[DATA_W-1], v};
  endfunction

  logic signed [DATA_W-1:0] bp_a [N_TERMS];
  logic signed [DATA_W-1:0] bp_b [N_TERMS];
  logic signed [DATA_W-1:0] bp_c [N_TERMS];
  logic signed [DATA_W-1:0] bp_d [N_TERMS];

  state_t                   state;
  logic [IDX_W-1:0]         term;
  logic signed [DATA_W-1:0] x_r;
  logic [DATA_W:0]          rem_r;
  logic [DATA_W:0]          den_r;
  logic [13:0]              quo_r;
  logic [3:0]               cnt_r;
  logic                     fix_r;
  logic [15:0]              fix_mu_r;

  logic                     cfg_ok;
  logic                     cls_fix;
  logic [15:0]              cls_mu;
  logic signed [DATA_W:0]   cls_num;
  logic signed [DATA_W:0]   cls_den;
  logic [DATA_W+1:0]        rem_sh;
  logic                     quo_bit;
  logic [DATA_W:0]          rem_sub;

  assign in_ready = rst_n && (state == IDLE);
  assign cfg_ok   = (32'(cfg_idx) < 32'(N_TERMS));

  // Sample capture: data only, no reset needed
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) x_r <= x;
  end

  // EVAL: classify the current term; differences are one bit wider so they cannot overflow
  always_comb begin
    cls_fix = 1'b1;
    cls_mu  = 16'h0000;
    cls_num = '0;
    cls_den = '1;
    if (x_r >= bp_b[term] && x_r <= bp_c[term]) begin
      cls_mu = 16'h7FFF;
    end else if (x_r <= bp_a[term] || x_r >= bp_d[term]) begin
      cls_mu = 16'h0000;
    end else if (x_r < bp_b[term]) begin
      cls_fix = 1'b0;
      cls_num = sext(x_r) - sext(bp_a[term]);
      cls_den = sext(bp_b[term]) - sext(bp_a[term]);
    end else begin
      cls_fix = 1'b0;
      cls_num = sext(bp_d[term]) - sext(x_r);
      cls_den = sext(bp_d[term]) - sext(bp_c[term]);
    end
  end

  // DIV: one restoring step; rem < den always, so the shifted remainder fits in DATA_W+2 bits
  assign rem_sh  = {rem_r, 1'b0};
  assign quo_bit = (rem_sh >= {1'b0, den_r});
  assign rem_sub = rem_sh[DATA_W:0] - den_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      term      <= '0;
      rem_r     <= '0;
      den_r     <= '0;
      quo_r     <= '0;
      cnt_r     <= '0;
      fix_r     <= 1'b0;
      fix_mu_r  <= '0;
      out_valid <= 1'b0;
      out_mu    <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      cfg_drop  <= 1'b0;
      for (int i = 0; i < N_TERMS; i++) begin
        bp_a[i] <= '0;
        bp_b[i] <= '0;
        bp_c[i] <= '0;
        bp_d[i] <= '0;
      end
    end else begin
      cfg_drop <= 1'b0;
      if (cfg_we) begin
        if (state == IDLE && cfg_ok) begin
          bp_a[cfg_idx] <= cfg_a;
          bp_b[cfg_idx] <= cfg_b;
          bp_c[cfg_idx] <= cfg_c;
          bp_d[cfg_idx] <= cfg_d;
        end else begin
          cfg_drop <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            term  <= '0;
            state <= EVAL;
          end
        end
        EVAL: begin
          fix_r    <= cls_fix;
          fix_mu_r <= cls_mu;
          rem_r    <= $unsigned(cls_num);
          den_r    <= $unsigned(cls_den);
          quo_r    <= '0;
          cnt_r    <= '0;
`ifdef TRAPEZOID_BANK_FASTPATH_EN
          if (cls_fix) begin
            out_valid <= 1'b1;
            out_mu    <= cls_mu;
            out_idx   <= term;
            out_last  <= (term == LAST_IDX);
            state     <= OUT;
          end else begin
            state <= DIV;
          end
`else
          state <= DIV;
`endif
        end
        DIV: begin
          rem_r <= quo_bit ? rem_sub : rem_sh[DATA_W:0];
          quo_r <= {quo_r[12:0], quo_bit};
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == 4'd14) begin
            out_valid <= 1'b1;
            out_mu    <= fix_r ? fix_mu_r : {1'b0, quo_r, quo_bit};
            out_idx   <= term;
            out_last  <= (term == LAST_IDX);
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              state <= IDLE;
            end else begin
              term  <= term + 1'b1;
              state <= EVAL;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
